// File: rtl/msh_node_router.sv
// 5-port XY-routed mesh node: per-input FIFOs feeding registered output stages,
// round-robin or fixed-priority arbitration per output, U-turn flits dropped and counted.
module msh_node_router #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COORD_W    = 4,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                mclk,
  input  logic                mrst,
  input  logic [COORD_W-1:0]  node_row,
  input  logic [COORD_W-1:0]  node_col,
  input  logic [4:0]          in_vld,
  input  logic [5*DATA_W-1:0] in_data,
  output logic [4:0]          in_rdy,
  output logic [4:0]          out_vld,
  output logic [5*DATA_W-1:0] out_data,
  input  logic [4:0]          out_rdy,
  output logic [15:0]         err_cnt
);
  localparam int unsigned NP = 5;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_S = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  // XY routing: resolve the column first, then the row
  function automatic logic [2:0] route_of(input logic [COORD_W-1:0] drow,
                                          input logic [COORD_W-1:0] dcol,
                                          input logic [COORD_W-1:0] row,
                                          input logic [COORD_W-1:0] col);
    logic [2:0] r;
    if (dcol > col)      r = P_E;
    else if (dcol < col) r = P_W;
    else if (drow > row) r = P_S;
    else if (drow < row) r = P_N;
    else                 r = P_L;
    return r;
  endfunction

  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : 3'(v);
  endfunction

  logic [DATA_W-1:0] mem      [NP][FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr   [NP];
  logic [PW-1:0]     wr_ptr   [NP];
  logic [CW-1:0]     cnt      [NP];
  logic [2:0]        rr       [NP];
  logic              rst_q;

  logic [DATA_W-1:0] head     [NP];
  logic [2:0]        rte      [NP];
  logic [NP-1:0]     req      [NP];
  logic [2:0]        win      [NP];
  logic [DATA_W-1:0] win_data [NP];
  logic [NP-1:0]     nonempty;
  logic [NP-1:0]     drop;
  logic [NP-1:0]     pop;
  logic [NP-1:0]     push;
  logic [NP-1:0]     free;
  logic [NP-1:0]     win_vld;
  logic [7:0]        req_x;
  logic [2:0]        idx;
  logic [2:0]        ndrop;
  logic [16:0]       err_sum;

  // Readiness comes from the registered count only; no same-cycle bypass on pop
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_rdy[i] = ~rst_q & (cnt[i] < CW'(FIFO_DEPTH));
    end
  end

  always_comb begin
    pop      = '0;
    ndrop    = '0;
    req_x    = '0;
    idx      = '0;
    nonempty = '0;
    drop     = '0;
    push     = '0;
    free     = '0;
    win_vld  = '0;
    for (int i = 0; i < NP; i++) begin
      head[i]     = mem[i][rd_ptr[i]];
      nonempty[i] = (cnt[i] != '0);
      rte[i]      = route_of(head[i][DATA_W-1 -: COORD_W],
                             head[i][DATA_W-COORD_W-1 -: COORD_W], node_row, node_col);
      // Local-to-local is the only legal same-port route
      drop[i]     = nonempty[i] && (rte[i] == 3'(i)) && (i != NP - 1);
      push[i]     = in_vld[i] & in_rdy[i];
      ndrop       = ndrop + 3'(drop[i]);
    end
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        req[o][i] = nonempty[i] & ~drop[i] & (rte[i] == 3'(o));
      end
    end
    for (int o = 0; o < NP; o++) begin
      free[o]     = ~out_vld[o] | out_rdy[o];
      win[o]      = '0;
      win_data[o] = '0;
      req_x       = 8'(req[o]);
      for (int k = 0; k < NP; k++) begin
        idx = (ARB_MODE == 0) ? wrap5(4'(rr[o]) + 4'(k)) : 3'(k);
        if (!win_vld[o] && req_x[idx]) begin
          win_vld[o] = 1'b1;
          win[o]     = idx;
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (win[o] == 3'(i)) win_data[o] = head[i];
        if (free[o] && win_vld[o] && (win[o] == 3'(i))) pop[i] = 1'b1;
      end
    end
    pop     = pop | drop;
    err_sum = {1'b0, err_cnt} + 17'(ndrop);
  end

  always_ff @(posedge mclk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      rst_q    <= 1'b1;
      err_cnt  <= '0;
      out_vld  <= '0;
      out_data <= '0;
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
        rr[i]     <= '0;
      end
    end else begin
      rst_q <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
      // Output register holds its flit until downstream takes it
      for (int o = 0; o < NP; o++) begin
        if (free[o]) begin
          if (win_vld[o]) begin
            out_vld[o]                   <= 1'b1;
            out_data[o*DATA_W +: DATA_W] <= win_data[o];
            rr[o]                        <= wrap5(4'(win[o]) + 4'd1);
          end else begin
            out_vld[o] <= 1'b0;
          end
        end
      end
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_msh_node_router.sv
// Bench for msh_node_router: directed scenarios plus random traffic against a
// queue-based reference model; a second instance exercises fixed priority.
module tb_msh_node_router;
  localparam int unsigned DW = 64;
  localparam int unsigned NP = 5;
  localparam int NODE_R = 2;
  localparam int NODE_C = 2;
  typedef logic [DW-1:0] flit_t;
  typedef flit_t fq_t[$];

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       node_row = 4'd2;
  logic [3:0]       node_col = 4'd2;
  logic [NP-1:0]    in_vld, in_rdy, out_vld, out_rdy;
  logic [NP*DW-1:0] in_data, out_data;
  logic [15:0]      err_cnt;
  logic [NP-1:0]    f_vld, f_in_rdy, f_out_vld, f_out_rdy;
  logic [NP*DW-1:0] f_data, f_out_data;
  logic [15:0]      f_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msh_node_router dut (
    .mclk(clk), .mrst(rst), .node_row(node_row), .node_col(node_col),
    .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .err_cnt(err_cnt));

  msh_node_router #(.ARB_MODE(1)) dut_fp (
    .mclk(clk), .mrst(rst), .node_row(node_row), .node_col(node_col),
    .in_vld(f_vld), .in_data(f_data), .in_rdy(f_in_rdy),
    .out_vld(f_out_vld), .out_data(f_out_data), .out_rdy(f_out_rdy), .err_cnt(f_err));

  // Reference model state (round-robin instance)
  fq_t           mq [NP];
  logic [NP-1:0] m_vld;
  flit_t         m_data [NP];
  int            m_rr [NP];
  int            m_err;
  bit            m_rstq;

  function automatic flit_t mk(int r, int c);
    return {4'(r), 4'(c), 24'($urandom), 32'($urandom)};
  endfunction

  function automatic int route(flit_t f);
    int dr, dc;
    dr = int'(f[63:60]);
    dc = int'(f[59:56]);
    if (dc > NODE_C) return 2;
    if (dc < NODE_C) return 3;
    if (dr > NODE_R) return 1;
    if (dr < NODE_R) return 0;
    return 4;
  endfunction

  function automatic logic [NP-1:0] m_rdy();
    logic [NP-1:0] r;
    for (int i = 0; i < NP; i++) r[i] = !m_rstq && (mq[i].size() < 4);
    return r;
  endfunction

  function automatic logic [NP*DW-1:0] m_dvec();
    logic [NP*DW-1:0] r = '0;
    for (int o = 0; o < NP; o++) if (m_vld[o]) r[o*DW +: DW] = m_data[o];
    return r;
  endfunction

  function automatic logic [NP*DW-1:0] vmask(logic [NP-1:0] v);
    logic [NP*DW-1:0] r = '0;
    for (int o = 0; o < NP; o++) r[o*DW +: DW] = v[o] ? '1 : '0;
    return r;
  endfunction

  // One clock of the reference model, computed from pre-edge inputs and state
  task automatic model_step();
    bit has [NP];
    flit_t hd [NP];
    int rt [NP];
    bit pp [NP];
    logic [NP-1:0] rdy;
    int w, i;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        m_data[p] = '0;
        m_rr[p] = 0;
      end
      m_vld = '0;
      m_err = 0;
      m_rstq = 1'b1;
      return;
    end
    rdy = m_rdy();
    for (int p = 0; p < NP; p++) begin
      has[p] = mq[p].size() > 0;
      hd[p] = has[p] ? mq[p][0] : '0;
      rt[p] = has[p] ? route(hd[p]) : -1;
      pp[p] = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      if (has[p] && rt[p] == p) begin
        pp[p] = 1'b1;
        if (m_err < 65535) m_err++;
      end
    end
    for (int o = 0; o < NP; o++) begin
      if (!m_vld[o] || out_rdy[o]) begin
        w = -1;
        for (int k = 0; k < NP; k++) begin
          i = (m_rr[o] + k) % NP;
          if (w < 0 && has[i] && !pp[i] && rt[i] == o) w = i;
        end
        if (w >= 0) begin
          m_vld[o] = 1'b1;
          m_data[o] = hd[w];
          pp[w] = 1'b1;
          m_rr[o] = (w + 1) % NP;
        end else begin
          m_vld[o] = 1'b0;
        end
      end
    end
    for (int p = 0; p < NP; p++) if (pp[p]) void'(mq[p].pop_front());
    for (int p = 0; p < NP; p++) if (in_vld[p] && rdy[p]) mq[p].push_back(in_data[p*DW +: DW]);
    m_rstq = 1'b0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 00000", out_vld); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0000", err_cnt); end
    checks++; if (in_rdy !== 5'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 00000", in_rdy); end
    rst = 1'b0;
    tick();
    checks++; if (in_rdy !== 5'b11111) begin errors++; $display("FAIL reset_release_rdy: got %b expected 11111", in_rdy); end
  endtask

  task automatic test_latency();
    flit_t f;
    f = mk(2, 5);
    in_vld = 5'b10000;
    in_data[4*DW +: DW] = f;
    tick();
    in_vld = '0;
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL lat_early: got %b expected 00000", out_vld); end
    checks++; if (in_rdy[4] !== 1'b1) begin errors++; $display("FAIL lat_rdy: got %b expected 1", in_rdy[4]); end
    tick();
    checks++; if (out_vld !== 5'b00100) begin errors++; $display("FAIL lat_vld: got %b expected 00100", out_vld); end
    checks++; if (out_data[2*DW +: DW] !== f) begin errors++; $display("FAIL lat_data: got %h expected %h", out_data[2*DW +: DW], f); end
    tick();
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL lat_drain: got %b expected 00000", out_vld); end
  endtask

  task automatic test_rr_burst();
    flit_t ex [3];
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 3; k++) ex[k] = mk(2, 5);
      in_vld = 5'b11001;
      in_data[0*DW +: DW] = ex[0];
      in_data[3*DW +: DW] = ex[1];
      in_data[4*DW +: DW] = ex[2];
      tick();
      in_vld = '0;
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (out_vld[2] !== 1'b1 || out_data[2*DW +: DW] !== ex[k]) begin
          errors++;
          $display("FAIL rr_order r%0d k%0d: got vld=%b %h expected vld=1 %h", round, k, out_vld[2], out_data[2*DW +: DW], ex[k]);
        end
      end
      tick();
      checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL rr_idle: got %b expected 00000", out_vld); end
    end
  endtask

  task automatic test_fp_starve();
    flit_t nf [6];
    flit_t wf, lf;
    flit_t ex [$];
    flit_t got [$];
    wf = mk(2, 5);
    lf = mk(2, 5);
    for (int k = 0; k < 6; k++) begin
      nf[k] = mk(2, 5);
      ex.push_back(nf[k]);
    end
    ex.push_back(wf);
    ex.push_back(lf);
    for (int n = 0; n < 14; n++) begin
      f_vld = '0;
      if (n < 6) begin
        f_vld[0] = 1'b1;
        f_data[0*DW +: DW] = nf[n];
      end
      if (n == 0) begin
        f_vld[3] = 1'b1;
        f_vld[4] = 1'b1;
        f_data[3*DW +: DW] = wf;
        f_data[4*DW +: DW] = lf;
      end
      tick();
      if (f_out_vld[2]) got.push_back(f_out_data[2*DW +: DW]);
    end
    f_vld = '0;
    checks++; if (got.size() !== ex.size()) begin errors++; $display("FAIL fp_count: got %0d expected %0d", got.size(), ex.size()); end
    for (int k = 0; k < ex.size() && k < got.size(); k++) begin
      checks++; if (got[k] !== ex[k]) begin errors++; $display("FAIL fp_order k%0d: got %h expected %h", k, got[k], ex[k]); end
    end
  endtask

  task automatic test_backpressure();
    flit_t f [5];
    flit_t got [$];
    out_rdy = 5'b11101;
    for (int k = 0; k < 5; k++) begin
      f[k] = mk(4, 2);
      checks++; if (in_rdy[4] !== 1'b1) begin errors++; $display("FAIL bp_rdy_before k%0d: got %b expected 1", k, in_rdy[4]); end
      in_vld = 5'b10000;
      in_data[4*DW +: DW] = f[k];
      tick();
    end
    checks++; if (in_rdy[4] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_rdy[4]); end
    in_data[4*DW +: DW] = mk(4, 2);
    tick();
    in_vld = '0;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (out_vld[1] !== 1'b1 || out_data[1*DW +: DW] !== f[0]) begin
        errors++;
        $display("FAIL bp_hold n%0d: got vld=%b %h expected vld=1 %h", n, out_vld[1], out_data[1*DW +: DW], f[0]);
      end
      checks++; if (in_rdy[4] !== 1'b0) begin errors++; $display("FAIL bp_full_hold n%0d: got %b expected 0", n, in_rdy[4]); end
      tick();
    end
    out_rdy = '1;
    for (int n = 0; n < 12; n++) begin
      if (out_vld[1]) got.push_back(out_data[1*DW +: DW]);
      tick();
    end
    checks++; if (got.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++; if (got[k] !== f[k]) begin errors++; $display("FAIL bp_order k%0d: got %h expected %h", k, got[k], f[k]); end
    end
    checks++; if (in_rdy[4] !== 1'b1) begin errors++; $display("FAIL bp_rdy_after: got %b expected 1", in_rdy[4]); end
  endtask

  task automatic test_uturn();
    flit_t fl;
    in_vld = 5'b00100;
    in_data[2*DW +: DW] = mk(2, 5);
    tick();
    in_vld = '0;
    tick();
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL uturn_cnt: got %0d expected 1", err_cnt); end
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL uturn_fwd: got %b expected 00000", out_vld); end
    tick();
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL uturn_fwd_late: got %b expected 00000", out_vld); end
    fl = mk(2, 2);
    in_vld = 5'b10000;
    in_data[4*DW +: DW] = fl;
    tick();
    in_vld = '0;
    tick();
    checks++; if (out_vld !== 5'b10000 || out_data[4*DW +: DW] !== fl) begin errors++; $display("FAIL local_loop: got vld=%b %h expected vld=10000 %h", out_vld, out_data[4*DW +: DW], fl); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL local_loop_cnt: got %0d expected 1", err_cnt); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      in_vld = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        in_data[p*DW +: DW] = mk($urandom_range(0, 4), $urandom_range(0, 4));
        out_rdy[p] = ($urandom_range(0, 3) != 0);
      end
      tick();
      checks++; if (out_vld !== m_vld) begin errors++; $display("FAIL rnd_vld c%0d: got %b expected %b", n, out_vld, m_vld); end
      checks++; if ((out_data & vmask(m_vld)) !== m_dvec()) begin errors++; $display("FAIL rnd_data c%0d: got %h expected %h", n, out_data & vmask(m_vld), m_dvec()); end
      checks++; if (in_rdy !== m_rdy()) begin errors++; $display("FAIL rnd_rdy c%0d: got %b expected %b", n, in_rdy, m_rdy()); end
      checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL rnd_err c%0d: got %0d expected %0d", n, err_cnt, m_err); end
    end
    in_vld = '0;
    out_rdy = '1;
    repeat (20) tick();
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL rnd_drain: got %b expected 00000", out_vld); end
  endtask

  task automatic test_saturate();
    logic any_out;
    any_out = 1'b0;
    out_rdy = '1;
    in_vld = 5'b01111;
    for (int n = 0; n < 16400; n++) begin
      in_data[0*DW +: DW] = mk(0, 2);
      in_data[1*DW +: DW] = mk(4, 2);
      in_data[2*DW +: DW] = mk(2, 4);
      in_data[3*DW +: DW] = mk(2, 0);
      tick();
      any_out = any_out | (|out_vld);
    end
    in_vld = '0;
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h expected ffff", err_cnt); end
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL sat_no_output: got %b expected 0", any_out); end
    in_vld = 5'b00001;
    in_data[0*DW +: DW] = mk(1, 2);
    tick();
    in_vld = '0;
    repeat (3) tick();
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", err_cnt); end
    checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL sat_model: got %h expected %h", err_cnt, 16'(m_err)); end
  endtask

  task automatic test_reset_mid();
    logic [NP-1:0] seen;
    out_rdy = 5'b00000;
    for (int n = 0; n < 6; n++) begin
      in_vld = 5'b11111;
      for (int p = 0; p < NP; p++) in_data[p*DW +: DW] = mk($urandom_range(0, 4), $urandom_range(0, 4));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_vld = '0;
    checks++; if (out_vld !== 5'b0) begin errors++; $display("FAIL mid_vld: got %b expected 00000", out_vld); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_data: got %h expected 0", out_data); end
    checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL mid_err: got %h expected 0000", err_cnt); end
    checks++; if (in_rdy !== 5'b0) begin errors++; $display("FAIL mid_rdy: got %b expected 00000", in_rdy); end
    out_rdy = '1;
    tick();
    checks++; if (in_rdy !== 5'b11111) begin errors++; $display("FAIL mid_rdy_release: got %b expected 11111", in_rdy); end
    seen = '0;
    repeat (10) begin
      tick();
      seen = seen | out_vld;
    end
    checks++; if (seen !== 5'b0) begin errors++; $display("FAIL mid_stale: got %b expected 00000", seen); end
  endtask

  initial begin
    rst = 1'b1;
    in_vld = '0;
    in_data = '0;
    out_rdy = '1;
    f_vld = '0;
    f_data = '0;
    f_out_rdy = '1;
    test_reset();
    test_latency();
    test_rr_burst();
    test_fp_starve();
    test_backpressure();
    test_uturn();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
